// File: rtl/blind_cycler_pkg.sv
// Shared constants and helpers for the blind_cycler open-loop value cycler.
package blind_cycler_pkg;

    localparam int unsigned DEF_WIDTH       = 3;
    localparam int unsigned DEF_MIN_VAL     = 0;
    localparam int unsigned DEF_MAX_VAL     = 7;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Reflected binary Gray code; callers truncate to their own width.
    function automatic logic [31:0] gray_enc(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/blind_cycler_sync.sv
// Multi-flop level synchroniser with a rising-edge pulse taken after the last stage.
module blind_cycler_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic level_o,
    output logic rise_c
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic [SYNC_STAGES-1:0] chain_d;
    logic                   hist_q;
    logic                   hist_d;

    always_comb begin
        chain_d = {chain_q[SYNC_STAGES-2:0], async_i};
        hist_d  = chain_q[SYNC_STAGES-1];
    end

    // Edge history resets with the chain so a level held through reset gives no pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= {SYNC_STAGES{RST_VAL}};
            hist_q  <= RST_VAL;
        end else begin
            chain_q <= chain_d;
            hist_q  <= hist_d;
        end
    end

    assign level_o = chain_q[SYNC_STAGES-1];
    assign rise_c  = chain_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/blind_cycler.sv
// Open-loop up/down value cycler stepped by an asynchronous strobe.
// Define BLIND_CYCLER_GRAY_EN to present out_num as a Gray code of the count.
module blind_cycler
    import blind_cycler_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned MIN_VAL     = DEF_MIN_VAL,
    parameter int unsigned MAX_VAL     = DEF_MAX_VAL,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dir,
    input  logic             nxt,
    output logic [WIDTH-1:0] out_num,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    if ((SYNC_STAGES < 2) || (MIN_VAL >= MAX_VAL) ||
        (64'(MAX_VAL) > ((64'(1) << WIDTH) - 64'(1)))) begin : g_bad_cfg
        $error("blind_cycler: illegal WIDTH/MIN_VAL/MAX_VAL/SYNC_STAGES");
    end

    logic nxt_s;
    logic step_c;
    logic dir_s;
    logic unused_dir_rise;

    blind_cycler_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (1'b1)
    ) u_sync_nxt (
        .clk     (clk),
        .rst     (rst),
        .async_i (nxt),
        .level_o (nxt_s),
        .rise_c  (step_c)
    );

    blind_cycler_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (1'b0)
    ) u_sync_dir (
        .clk     (clk),
        .rst     (rst),
        .async_i (dir),
        .level_o (dir_s),
        .rise_c  (unused_dir_rise)
    );

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] out_num_q;
    logic [WIDTH-1:0] out_num_d;
    logic             wrap_q;
    logic             wrap_d;
    logic [WIDTH-1:0] out_rst;

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (step_c) begin
            if (dir_s == DIR_UP) begin
                if (count_q == MAX_W) begin
                    count_d = MIN_W;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == MIN_W) begin
                    count_d = MAX_W;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    // Output encoding is registered alongside the count so out_num comes straight from flops.
    always_comb begin
`ifdef BLIND_CYCLER_GRAY_EN
        out_num_d = WIDTH'(gray_enc(32'(count_d)));
        out_rst   = WIDTH'(gray_enc(32'(MIN_W)));
`else
        out_num_d = count_d;
        out_rst   = MIN_W;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= MIN_W;
            out_num_q <= out_rst;
            wrap_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            out_num_q <= out_num_d;
            wrap_q    <= wrap_d;
        end
    end

    assign out_num = out_num_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_blind_cycler.sv
// Scoreboard bench for blind_cycler: stimulus pushes expected steps, a monitor pops on every output event.
module tb_blind_cycler;
    import blind_cycler_pkg::*;

    localparam int unsigned W     = DEF_WIDTH;
    localparam int          MINV  = int'(DEF_MIN_VAL);
    localparam int          MAXV  = int'(DEF_MAX_VAL);
    localparam int          RANGE = MAXV - MINV + 1;
    localparam int          LAT   = int'(DEF_SYNC_STAGES) + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         dir = 1'b0;
    logic         nxt = 1'b0;
    logic [W-1:0] out_num;
    logic         wrap;

    blind_cycler #(
        .WIDTH       (W),
        .MIN_VAL     (DEF_MIN_VAL),
        .MAX_VAL     (DEF_MAX_VAL),
        .SYNC_STAGES (DEF_SYNC_STAGES)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .dir     (dir),
        .nxt     (nxt),
        .out_num (out_num),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] out;
        logic         wrap;
        int           due;
        int           val;
    } exp_t;

    exp_t         sb[$];
    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;
    int           model_v  = MINV;
    logic [W-1:0] last_out;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] enc(input int v);
        logic [W-1:0] b;
        b = W'(v);
`ifdef BLIND_CYCLER_GRAY_EN
        return b ^ (b >> 1);
`else
        return b;
`endif
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: the value walks the ring [MINV, MAXV] by +/-1, wrap flags crossing the seam.
    task automatic model_step(input logic d);
        exp_t e;
        if (d == DIR_UP) begin
            model_v = MINV + ((model_v - MINV + 1) % RANGE);
            e.wrap  = (model_v == MINV);
        end else begin
            model_v = MINV + ((model_v - MINV + RANGE - 1) % RANGE);
            e.wrap  = (model_v == MAXV);
        end
        e.val = model_v;
        e.out = enc(model_v);
        e.due = cyc + LAT;
        sb.push_back(e);
    endtask

    // One request: nxt low for lo cycles, then high for hi cycles; inputs change on negedge.
    task automatic step(input logic d, input int lo, input int hi);
        @(negedge clk);
        dir = d;
        nxt = 1'b0;
        repeat (lo - 1) @(negedge clk);
        @(negedge clk);
        nxt = 1'b1;
        model_step(d);
        repeat (hi - 1) @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", sb.size(), 0);
    endtask

    // Monitor: any change of out_num or a wrap pulse is one DUT event.
    always @(negedge clk) begin
        if (rst) begin
            last_out = enc(MINV);
        end else if (out_num !== last_out || wrap !== 1'b0) begin
            if (sb.size() == 0) begin
                check("unexpected_event", int'(out_num), int'(last_out));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_num", int'(out_num), int'(e.out));
                check("wrap", int'(wrap), int'(e.wrap));
                check("latency_cycle", cyc, e.due);
`ifdef BLIND_CYCLER_GRAY_EN
                check("gray_one_bit", $countones(out_num ^ last_out), 1);
`endif
            end
            last_out = out_num;
        end
    end

    initial begin
        // Reset held with nxt toggling: outputs pinned at reset values.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            nxt = ~nxt;
            check("rst_out_num", int'(out_num), int'(enc(MINV)));
            check("rst_wrap", int'(wrap), 0);
        end

        // nxt held high through reset release must not step.
        @(negedge clk);
        nxt = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("level_thru_reset", int'(out_num), int'(enc(MINV)));
        step(DIR_UP, 3, 20);
        drain();
        check("level_one_step", int'(out_num), int'(enc(MINV + 1)));

        // Up count to 5 with 40 ns nxt period.
        for (int i = 0; i < 4; i++) step(DIR_UP, 2, 2);
        drain();
        check("up_to_5", int'(out_num), int'(enc(MINV + 5)));

        // Asynchronous reset mid-run takes effect before the next edge.
        @(posedge clk);
        #3;
        rst = 1'b1;
        sb.delete();
        model_v = MINV;
        #1;
        check("async_rst_out", int'(out_num), int'(enc(MINV)));
        check("async_rst_wrap", int'(wrap), 0);
        @(negedge clk);
        nxt = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Eight up-steps: full ring with a wrap on the last.
        for (int i = 0; i < 8; i++) step(DIR_UP, 2, 2);
        drain();
        check("up_wrap_final", int'(out_num), int'(enc(MINV)));

        // Reverse direction at the bottom: wrap to MAX, then plain decrement.
        step(DIR_DOWN, 2, 2);
        step(DIR_DOWN, 2, 2);
        drain();
        check("down_final", int'(out_num), int'(enc(MAXV - 1)));

        // Randomised directions and pulse widths.
        for (int i = 0; i < 60; i++) begin
            step(logic'($urandom_range(0, 1)), int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
        end
        drain();
        check("random_final", int'(out_num), int'(enc(model_v)));

        repeat (5) @(negedge clk);
        check("no_spurious", int'(out_num), int'(enc(model_v)));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/blind_cycler.md
Name: blind_cycler

Overview:
- Free-running 3-bit (default) value cycler, stepped by an external "next" strobe. Each step moves up or down by one according to a direction input.
- Open-loop ("blind"): no acknowledge and no feedback to the requester. The value wraps at the configured range limits.
- Sits between an asynchronous/slow control source (button, handshake-less strobe) and downstream selection logic that consumes out_num.

Parameters:
- WIDTH, 3, bit width of out_num and of the internal count.
- MIN_VAL, 0, lowest value in the cycle. Reset value.
- MAX_VAL, 7, highest value in the cycle. Elaboration error unless MIN_VAL < MAX_VAL <= 2**WIDTH-1.
- SYNC_STAGES, 2, flop depth of the input synchronisers. Minimum 2.

Ports:
- clk  input  1  single system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- dir  input  1  direction, asynchronous to clk: 0 = count up, 1 = count down.
- nxt  input  1  step strobe, asynchronous to clk; each 0->1 transition requests one step.
- out_num  output  WIDTH  current cycle value, registered.
- wrap  output  1  one-cycle pulse, registered, asserted in the cycle out_num wrapped.

Interface: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset (async assert, released synchronously by the upstream reset tree):
  - count = MIN_VAL; out_num reflects count.
  - wrap = 0.
  - dir synchroniser = 0.
  - nxt synchroniser and edge-history flop = 1. A nxt held high across reset release therefore produces no step.
- Synchronisation: nxt and dir each pass through SYNC_STAGES flops, giving nxt_s and dir_s. nxt_d = nxt_s delayed one clk.
- Step detect: step = nxt_s & ~nxt_d. This is a one-cycle pulse per rising edge of nxt. A level held high yields exactly one step.
- Count update, at the clock edge ending a step cycle:
  - dir_s=0: count = (count==MAX_VAL) ? MIN_VAL : count+1.
  - dir_s=1: count = (count==MIN_VAL) ? MAX_VAL : count-1.
  - wrap = 1 for that one cycle when the wrap branch is taken, else 0.
- No step: count holds and wrap = 0.
- Latency: a nxt rise sampled on clk edge k changes out_num at edge k+SYNC_STAGES (k+2 by default).
- Direction: dir_s is the value sampled in the step cycle. A dir change and an nxt edge arriving together resolve to whichever dir_s value is present in the step cycle; no error is flagged.
- nxt pulses narrower than one clk period may be lost. nxt must stay stable high ≥1 clk and low ≥1 clk per step.
- Reset mid-operation: out_num goes to MIN_VAL immediately (asynchronous), wrap clears, and any pending step is discarded.
- Arithmetic is unsigned, WIDTH bits. out_num never leaves [MIN_VAL, MAX_VAL].

Optional Feature:
- Macro: BLIND_CYCLER_GRAY_EN.
- Defined: out_num = count ^ (count >> 1), a Gray code of the internal binary count, driven directly from registers. Reset value is Gray(MIN_VAL). wrap is unchanged.
- Undefined: out_num = count, plain binary.

Decomposition:
- Package blind_cycler_pkg holds:
  - Default constants: WIDTH, MIN_VAL, MAX_VAL, SYNC_STAGES.
  - DIR_UP = 1'b0 and DIR_DOWN = 1'b1.
  - A Gray-encode function.
- One sub-module, blind_cycler_sync:
  - Parameterised SYNC_STAGES and reset value.
  - Outputs the synchronised level plus a rising-edge pulse.
  - Instantiated for nxt (reset 1, edge used) and for dir (reset 0, level used).
- Top level holds the wrap-around counter and wrap flop.

Test Plan:
- Reset: rst=1 with nxt toggling -> out_num=0, wrap=0 throughout. Asserting rst with out_num=5 mid-run -> out_num=0 before the next clk edge.
- Up count: dir=0, five nxt rising edges (nxt 40 ns period, clk 10 ns) -> out_num 1,2,3,4,5. Each change lands 2 clk edges after nxt is first sampled high.
- Up wrap: eight steps from 0 with dir=0 -> 1..7 then 0. wrap=1 for exactly one cycle coincident with the 7->0 update.
- Down wrap: dir=1 at out_num=0, two steps -> 7 (wrap pulse) then 6 (no wrap). dir changed from 0 to 1 mid-sequence -> next step decrements.
- Level/reset edge: nxt held high through reset release -> out_num stays 0. nxt then low 3 cycles and high 20 cycles -> exactly one step, out_num=1.
- With BLIND_CYCLER_GRAY_EN: eight up-steps from reset -> out_num 1,3,2,6,7,5,4,0. Exactly one bit changes per step, including the wrap.
